spu_issue_scoreboard: RTL and testbench
=======================================

// Module: spu_issue_scoreboard
// PURPOSE
// Issue-stage scoreboard and writeback scheduler for the SPU execution units, Byte unit included.
// Tracks every in-flight instruction by destination register and cycles-to-writeback.
// Holds issue on RAW/WAW hazards and on writeback-port collisions; retires one result per cycle.
// Applies flush to young in-flight entries, matching the flush point of the unit pipelines.
// PARAMETERS
// DEPTH      8   scoreboard slots; must exceed the largest unit latency
// FLUSH_AGE  2   entries younger than this many cycles are killed by flush
// PORTS
// clk          in   1    clock
// reset        in   1    synchronous, active-high
// flush        in   1    branch mispredict; kill young entries, block issue this cycle
// issue_valid  in   1    decoder presents an instruction
// issue_unit   in   3    unit code (spu_pkg::unit_e); Byte unit = 3'd4
// issue_rt     in   7    destination register
// issue_ra     in   7    source A
// issue_rb     in   7    source B
// issue_rc     in   7    source C
// src_used     in   3    {ra,rb,rc} used flags
// rt_write     in   1    instruction writes rt (0 for stores/branches)
// issue_ready  out  1    combinational; instruction fires when issue_valid & issue_ready
// stall_raw    out  1    combinational; source/dest hazard against an in-flight entry
// stall_wb     out  1    combinational; writeback slot already reserved
// wb_valid     out  1    registered; a result is written to the register file this cycle
// wb_rt        out  7    registered; register being written
// wb_unit      out  3    registered; unit that produced it
// busy         out  1    registered; any slot valid
// BEHAVIOUR
// - Reset: all slots invalid; wb_valid=0, wb_rt=0, wb_unit=0, busy=0.
// - Latency L = spu_pkg::UNIT_LAT[issue_unit], range 1..DEPTH-1. Byte unit L=4.
// - slot[k] = {valid, rt, unit, lat}: the entry writes back in k+1 cycles.
// - Each cycle slot[k] <= slot[k+1]; slot[DEPTH-1] <= invalid.
// - slot[0] retires: wb_valid/wb_rt/wb_unit <= slot[0] next cycle.
// - Fire = issue_valid & issue_ready. On fire with rt_write=1, slot[L-1] <= {1,rt,unit,L}.
// - Fire with rt_write=0 reserves nothing.
// - stall_wb = rt_write & slot[L].valid. That entry shifts into L-1 on this edge.
// - stall_raw = any valid slot[k] whose rt equals a used source, or equals issue_rt when rt_write.
//   - No early forwarding credit; the match clears the cycle after the entry leaves slot[0].
// - issue_ready = !stall_raw & !stall_wb & !flush & !reset.
// - Flush: entry age = lat-1-k after the shift. Entries with age < FLUSH_AGE are invalidated.
//   - Shift and retirement of older entries proceed in the same cycle.
//   - A flushed entry never produces wb_valid.
// - Flush and issue_valid in the same cycle: nothing fires, issue_ready=0.
// - Reset mid-operation: all in-flight entries dropped; no writeback emitted.
// - Slot count only limits latency: DEPTH > max L guarantees no overflow.
//   - At most one insert per cycle; one retire per cycle.
// - Register 0 gets no special treatment.
// STRUCTURE
// - spu_pkg: unit_e codes (SF1=1, SF2=2, FP=3, BYTE=4, LS=5, PERM=6, BR=7).
// - spu_pkg: UNIT_LAT table (SF1=2, SF2=4, FP=6, BYTE=4, LS=6, PERM=4, BR=1).
// - spu_pkg: sb_entry_t struct.
// - One sub-module, sb_match: compares one 7-bit register against DEPTH slots and returns a hit.
//   - Instantiated four times: ra, rb, rc, rt.
// - The slot array and control stay in this module.
// TESTING
// - Reset, then Byte issue rt=5.
//   -> slot[3] valid; wb_valid=1 with wb_rt=5, wb_unit=4 exactly 4 cycles after fire; busy low afterwards.
// - Byte rt=5, then the next cycle ra=5 used.
//   -> stall_raw=1 until the cycle after wb of r5; then it fires.
// - FP (L=6) rt=9 at t, then Byte (L=4) rt=10 at t+2.
//   -> stall_wb=1 at t+2, fires at t+3; wb r9 and r10 on consecutive cycles.
// - Byte rt=7 at t, flush at t+1.
//   -> entry killed, no wb for r7; an older FP entry issued at t-3 still writes back.
// - flush with issue_valid=1 and no hazard.
//   -> issue_ready=0, no slot inserted.
// - Store (rt_write=0) with rt=3 while r3 is idle.
//   -> fires, no wb_valid ever; a later issue reading r3 does not stall.

Source files
------------

// File: rtl/spu_pkg.sv
// Shared types for the SPU issue stage: unit codes, per-unit result latency, scoreboard entry.
package spu_pkg;

  typedef enum logic [2:0] {
    UNIT_NONE = 3'd0,
    UNIT_SF1  = 3'd1,
    UNIT_SF2  = 3'd2,
    UNIT_FP   = 3'd3,
    UNIT_BYTE = 3'd4,
    UNIT_LS   = 3'd5,
    UNIT_PERM = 3'd6,
    UNIT_BR   = 3'd7
  } unit_e;

  // Indexed by unit code, entry 0 first in the concatenation is BR (index 7).
  localparam logic [7:0][2:0] UNIT_LAT = {
    3'd1,  // BR
    3'd4,  // PERM
    3'd6,  // LS
    3'd4,  // BYTE
    3'd6,  // FP
    3'd4,  // SF2
    3'd2,  // SF1
    3'd1   // NONE
  };

  typedef struct packed {
    logic       valid;
    logic [6:0] rt;
    logic [2:0] unit;
    logic [2:0] lat;
  } sb_entry_t;

  function automatic logic [2:0] unit_lat(input logic [2:0] unit);
    return UNIT_LAT[unit];
  endfunction

endpackage

// File: rtl/spu_issue_scoreboard_sb_match.sv
// Compares one register number against every scoreboard slot; hit when any valid slot matches.
module sb_match #(
  parameter int DEPTH = 8
) (
  input  logic [6:0]            reg_id,
  input  logic                  enable,
  input  logic [DEPTH-1:0]      slot_valid,
  input  logic [DEPTH-1:0][6:0] slot_rt,
  output logic                  hit
);

  logic [DEPTH-1:0] slot_hit;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign slot_hit[gi] = slot_valid[gi] & (slot_rt[gi] == reg_id);
    end
  endgenerate

  assign hit = enable & (|slot_hit);

endmodule

// File: rtl/spu_issue_scoreboard.sv
// Issue scoreboard: a shift-register of in-flight results indexed by cycles-to-writeback,
// with RAW/WAW and writeback-port hazard detection and age-based flush.
module spu_issue_scoreboard
  import spu_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int FLUSH_AGE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       issue_valid,
  input  logic [2:0] issue_unit,
  input  logic [6:0] issue_rt,
  input  logic [6:0] issue_ra,
  input  logic [6:0] issue_rb,
  input  logic [6:0] issue_rc,
  input  logic [2:0] src_used,
  input  logic       rt_write,
  output logic       issue_ready,
  output logic       stall_raw,
  output logic       stall_wb,
  output logic       wb_valid,
  output logic [6:0] wb_rt,
  output logic [2:0] wb_unit,
  output logic       busy
);

  localparam int IW = $clog2(DEPTH);

  sb_entry_t             slot_reg  [DEPTH];
  sb_entry_t             slot_next [DEPTH];
  logic [DEPTH-1:0]      slot_valid;
  logic [DEPTH-1:0][6:0] slot_rt;
  logic [DEPTH-1:0]      next_valid;

  logic [2:0]    lat;
  logic [IW-1:0] lat_idx;
  logic          hit_ra, hit_rb, hit_rc, hit_rt;
  logic          fire, insert, retire_kill;
  sb_entry_t     new_entry;

  assign lat       = unit_lat(issue_unit);
  assign lat_idx   = IW'(lat);
  assign new_entry = '{valid: 1'b1, rt: issue_rt, unit: issue_unit, lat: lat};

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
      assign slot_valid[gi] = slot_reg[gi].valid;
      assign slot_rt[gi]    = slot_reg[gi].rt;
      assign next_valid[gi] = slot_next[gi].valid;
    end
  endgenerate

  sb_match #(.DEPTH(DEPTH)) u_match_ra (
    .reg_id(issue_ra), .enable(src_used[2]), .slot_valid(slot_valid), .slot_rt(slot_rt), .hit(hit_ra)
  );
  sb_match #(.DEPTH(DEPTH)) u_match_rb (
    .reg_id(issue_rb), .enable(src_used[1]), .slot_valid(slot_valid), .slot_rt(slot_rt), .hit(hit_rb)
  );
  sb_match #(.DEPTH(DEPTH)) u_match_rc (
    .reg_id(issue_rc), .enable(src_used[0]), .slot_valid(slot_valid), .slot_rt(slot_rt), .hit(hit_rc)
  );
  sb_match #(.DEPTH(DEPTH)) u_match_rt (
    .reg_id(issue_rt), .enable(rt_write), .slot_valid(slot_valid), .slot_rt(slot_rt), .hit(hit_rt)
  );

  assign stall_raw   = hit_ra | hit_rb | hit_rc | hit_rt;
  // slot[L] is about to shift into slot[L-1], exactly where the new result would land.
  assign stall_wb    = rt_write & slot_valid[lat_idx];
  assign issue_ready = !stall_raw && !stall_wb && !flush && !reset;
  assign fire        = issue_valid & issue_ready;
  assign insert      = fire & rt_write;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      sb_entry_t shifted;
      logic      young;
      if (gi < DEPTH - 1) begin : g_up
        assign shifted = slot_reg[gi+1];
      end else begin : g_top
        assign shifted = '0;
      end
      // Age after the shift is lat-1-gi, i.e. lat-(source slot index).
      assign young = (int'(shifted.lat) - gi - 1) < FLUSH_AGE;
      assign slot_next[gi] = (insert && (int'(lat) == gi + 1)) ? new_entry :
                             (flush && young)                   ? sb_entry_t'('0) :
                                                                  shifted;
    end
  endgenerate

  // The retiring entry shifts to "slot -1", so its post-shift age equals its latency.
  assign retire_kill = flush && (int'(slot_reg[0].lat) < FLUSH_AGE);

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_reg <= '{default: '0};
      wb_valid <= 1'b0;
      wb_rt    <= '0;
      wb_unit  <= '0;
      busy     <= 1'b0;
    end else begin
      slot_reg <= slot_next;
      wb_valid <= slot_reg[0].valid & !retire_kill;
      wb_rt    <= slot_reg[0].rt;
      wb_unit  <= slot_reg[0].unit;
      busy     <= |next_valid;
    end
  end

endmodule

// File: tb/tb_spu_issue_scoreboard.sv
// Self-checking bench for spu_issue_scoreboard: directed scenarios plus randomized traffic
// checked against a cycle-accounting model of in-flight results.
module tb_spu_issue_scoreboard;

  logic       clk = 1'b0;
  logic       reset, flush, issue_valid, rt_write;
  logic [2:0] issue_unit, src_used;
  logic [6:0] issue_rt, issue_ra, issue_rb, issue_rc;
  logic       issue_ready, stall_raw, stall_wb, wb_valid, busy;
  logic [6:0] wb_rt;
  logic [2:0] wb_unit;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int rt;
    int unit;
    int lat;
    int fire;
  } ent_t;

  spu_issue_scoreboard dut (
    .clk(clk), .reset(reset), .flush(flush), .issue_valid(issue_valid),
    .issue_unit(issue_unit), .issue_rt(issue_rt), .issue_ra(issue_ra),
    .issue_rb(issue_rb), .issue_rc(issue_rc), .src_used(src_used),
    .rt_write(rt_write), .issue_ready(issue_ready), .stall_raw(stall_raw),
    .stall_wb(stall_wb), .wb_valid(wb_valid), .wb_rt(wb_rt), .wb_unit(wb_unit),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int lat_of(input int unit);
    case (unit)
      1: return 2;
      2: return 4;
      3: return 6;
      4: return 4;
      5: return 6;
      6: return 4;
      7: return 1;
      default: return 1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; flush = 1'b0; issue_valid = 1'b0; rt_write = 1'b0;
    issue_unit = 3'd0; src_used = 3'd0;
    issue_rt = 7'd0; issue_ra = 7'd0; issue_rb = 7'd0; issue_rc = 7'd0;
  endtask

  task automatic set_issue(input int unit, input int rt, input int ra, input int used, input int wr);
    issue_valid = 1'b1;
    issue_unit  = 3'(unit);
    issue_rt    = 7'(rt);
    issue_ra    = 7'(ra);
    issue_rb    = 7'd0;
    issue_rc    = 7'd0;
    src_used    = 3'(used);
    rt_write    = 1'(wr);
  endtask

  task automatic drain();
    idle();
    repeat (12) tick();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    @(negedge clk);
    total++;
    if (issue_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_low got=%b want=0", issue_ready); end
    tick();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%b want=0", wb_valid); end
    total++;
    if (wb_rt !== 7'd0) begin bad++; $display("FAIL reset_wb_rt got=%0d want=0", wb_rt); end
    total++;
    if (wb_unit !== 3'd0) begin bad++; $display("FAIL reset_wb_unit got=%0d want=0", wb_unit); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++;
    if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_idle got=%b want=1", issue_ready); end
    tick();
    $display("test_reset: done");
  endtask

  task automatic test_byte_wb();
    drain();
    set_issue(4, 5, 0, 0, 1);
    @(negedge clk);
    total++;
    if (issue_ready !== 1'b1) begin bad++; $display("FAIL byte_fire got=%b want=1", issue_ready); end
    tick();
    idle();
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      total++;
      if (wb_valid !== (k == 5)) begin bad++; $display("FAIL byte_wb_valid cyc=%0d got=%b want=%b", k, wb_valid, k == 5); end
      if (k == 5) begin
        total++;
        if (wb_rt !== 7'd5) begin bad++; $display("FAIL byte_wb_rt got=%0d want=5", wb_rt); end
        total++;
        if (wb_unit !== 3'd4) begin bad++; $display("FAIL byte_wb_unit got=%0d want=4", wb_unit); end
      end
      if (k == 1 || k == 5) begin
        total++;
        if (busy !== (k == 1)) begin bad++; $display("FAIL byte_busy cyc=%0d got=%b want=%b", k, busy, k == 1); end
      end
      tick();
    end
    $display("test_byte_wb: byte r5 issued, writeback watched");
  endtask

  task automatic test_raw();
    int fired_at;
    drain();
    fired_at = -1;
    set_issue(4, 5, 0, 0, 1);
    @(negedge clk);
    tick();
    set_issue(1, 20, 5, 3'b100, 1);
    for (int k = 1; k < 20 && fired_at < 0; k++) begin
      @(negedge clk);
      total++;
      if (stall_raw !== (k < 5)) begin bad++; $display("FAIL raw_stall cyc=%0d got=%b want=%b", k, stall_raw, k < 5); end
      if (issue_ready === 1'b1) fired_at = k;
      tick();
    end
    idle();
    total++;
    if (fired_at != 5) begin bad++; $display("FAIL raw_fire_cycle got=%0d want=5", fired_at); end
    $display("test_raw: dependent issue fired at cycle %0d", fired_at);
  endtask

  task automatic test_wb_collision();
    int  byte_at;
    drain();
    byte_at = -1;
    for (int k = 0; k <= 12; k++) begin
      idle();
      if (k == 0) set_issue(3, 9, 0, 0, 1);
      else if (k >= 2 && byte_at < 0) set_issue(4, 10, 0, 0, 1);
      @(negedge clk);
      if (k == 2) begin
        total++;
        if (stall_wb !== 1'b1) begin bad++; $display("FAIL coll_stall_wb got=%b want=1", stall_wb); end
        total++;
        if (stall_raw !== 1'b0) begin bad++; $display("FAIL coll_stall_raw got=%b want=0", stall_raw); end
      end
      if (k >= 2 && byte_at < 0 && issue_ready === 1'b1) byte_at = k;
      total++;
      if (wb_valid !== (k == 7 || k == 8)) begin bad++; $display("FAIL coll_wb_valid cyc=%0d got=%b want=%b", k, wb_valid, k == 7 || k == 8); end
      if (k == 7 || k == 8) begin
        total++;
        if (wb_rt !== ((k == 7) ? 7'd9 : 7'd10)) begin bad++; $display("FAIL coll_wb_rt cyc=%0d got=%0d want=%0d", k, wb_rt, (k == 7) ? 9 : 10); end
      end
      tick();
    end
    idle();
    total++;
    if (byte_at != 3) begin bad++; $display("FAIL coll_fire_cycle got=%0d want=3", byte_at); end
    $display("test_wb_collision: byte fired at cycle %0d", byte_at);
  endtask

  task automatic test_flush();
    drain();
    for (int k = 0; k <= 14; k++) begin
      idle();
      if (k == 0) set_issue(3, 11, 0, 0, 1);
      if (k == 3) set_issue(4, 7, 0, 0, 1);
      if (k == 4) begin
        set_issue(7, 20, 0, 0, 1);
        flush = 1'b1;
      end
      @(negedge clk);
      if (k == 3) begin
        total++;
        if (issue_ready !== 1'b1) begin bad++; $display("FAIL flush_byte_fire got=%b want=1", issue_ready); end
      end
      if (k == 4) begin
        total++;
        if (issue_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", issue_ready); end
        total++;
        if ((stall_raw | stall_wb) !== 1'b0) begin bad++; $display("FAIL flush_no_hazard got=%b want=0", stall_raw | stall_wb); end
      end
      total++;
      if (wb_valid !== (k == 7)) begin bad++; $display("FAIL flush_wb_valid cyc=%0d got=%b want=%b", k, wb_valid, k == 7); end
      if (k == 7) begin
        total++;
        if (wb_rt !== 7'd11) begin bad++; $display("FAIL flush_wb_rt got=%0d want=11", wb_rt); end
      end
      if (k == 14) begin
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", busy); end
      end
      tick();
    end
    idle();
    $display("test_flush: young byte killed, older fp retired");
  endtask

  task automatic test_store();
    drain();
    for (int k = 0; k <= 8; k++) begin
      idle();
      if (k == 0) set_issue(5, 3, 0, 0, 0);
      if (k == 1) set_issue(1, 21, 3, 3'b100, 1);
      @(negedge clk);
      if (k == 0 || k == 1) begin
        total++;
        if (issue_ready !== 1'b1) begin bad++; $display("FAIL store_ready cyc=%0d got=%b want=1", k, issue_ready); end
      end
      if (k == 1) begin
        total++;
        if (stall_raw !== 1'b0) begin bad++; $display("FAIL store_raw got=%b want=0", stall_raw); end
      end
      total++;
      if (wb_valid !== (k == 4)) begin bad++; $display("FAIL store_wb_valid cyc=%0d got=%b want=%b", k, wb_valid, k == 4); end
      if (k == 4) begin
        total++;
        if (wb_rt !== 7'd21) begin bad++; $display("FAIL store_wb_rt got=%0d want=21", wb_rt); end
      end
      tick();
    end
    idle();
    $display("test_store: store reserved nothing");
  endtask

  task automatic test_reset_mid();
    drain();
    for (int k = 0; k <= 10; k++) begin
      idle();
      if (k == 0) set_issue(4, 12, 0, 0, 1);
      if (k == 2) reset = 1'b1;
      @(negedge clk);
      total++;
      if (wb_valid !== 1'b0) begin bad++; $display("FAIL rstmid_wb_valid cyc=%0d got=%b want=0", k, wb_valid); end
      if (k == 3) begin
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
      end
      tick();
    end
    idle();
    $display("test_reset_mid: in-flight byte dropped");
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t nq[$];
    ent_t e;
    int   lnew, wbc;
    logic x_raw, x_wb, x_ready, x_wbv, x_busy, do_fire;
    int   x_rt, x_unit;
    drain();
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 99) == 0);
      flush       = ($urandom_range(0, 19) == 0);
      issue_valid = ($urandom_range(0, 9) < 7);
      issue_unit  = 3'($urandom_range(1, 7));
      issue_rt    = 7'($urandom_range(0, 7));
      issue_ra    = 7'($urandom_range(0, 7));
      issue_rb    = 7'($urandom_range(0, 7));
      issue_rc    = 7'($urandom_range(0, 7));
      src_used    = 3'($urandom_range(0, 7));
      rt_write    = ($urandom_range(0, 4) != 0);
      @(negedge clk);
      lnew = lat_of(int'(issue_unit));
      x_raw = 1'b0; x_wb = 1'b0; x_wbv = 1'b0; x_busy = 1'b0; x_rt = 0; x_unit = 0;
      foreach (q[i]) begin
        e = q[i];
        if (c > e.fire && c <= e.fire + e.lat) begin
          x_busy = 1'b1;
          if ((src_used[2] && int'(issue_ra) == e.rt) || (src_used[1] && int'(issue_rb) == e.rt) ||
              (src_used[0] && int'(issue_rc) == e.rt) || (rt_write && int'(issue_rt) == e.rt))
            x_raw = 1'b1;
          if (rt_write && e.fire + e.lat == c + lnew) x_wb = 1'b1;
        end
        if (e.fire + e.lat + 1 == c) begin
          x_wbv = 1'b1; x_rt = e.rt; x_unit = e.unit;
        end
      end
      x_ready = !x_raw && !x_wb && !flush && !reset;
      total++;
      if (issue_ready !== x_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", c, issue_ready, x_ready); end
      total++;
      if (stall_raw !== x_raw) begin bad++; $display("FAIL rnd_stall_raw cyc=%0d got=%b want=%b", c, stall_raw, x_raw); end
      total++;
      if (stall_wb !== x_wb) begin bad++; $display("FAIL rnd_stall_wb cyc=%0d got=%b want=%b", c, stall_wb, x_wb); end
      total++;
      if (wb_valid !== x_wbv) begin bad++; $display("FAIL rnd_wb_valid cyc=%0d got=%b want=%b", c, wb_valid, x_wbv); end
      total++;
      if (busy !== x_busy) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", c, busy, x_busy); end
      if (x_wbv) begin
        total++;
        if (int'(wb_rt) != x_rt || int'(wb_unit) != x_unit)
          begin bad++; $display("FAIL rnd_wb_data cyc=%0d got=%0d/%0d want=%0d/%0d", c, wb_rt, wb_unit, x_rt, x_unit); end
      end
      do_fire = issue_valid && x_ready;
      nq.delete();
      if (!reset) begin
        foreach (q[i]) begin
          e = q[i];
          if (e.fire + e.lat + 1 > c && !(flush && e.fire == c - 1)) nq.push_back(e);
        end
        if (do_fire && rt_write) begin
          e.rt = int'(issue_rt); e.unit = int'(issue_unit); e.lat = lnew; e.fire = c;
          nq.push_back(e);
        end
      end
      q = nq;
      tick();
    end
    idle();
    drain();
    $display("test_random: 3000 cycles of mixed traffic");
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_byte_wb();
    test_raw();
    test_wb_collision();
    test_flush();
    test_store();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
